// File: rtl/divider_sequencer.sv
// Valid/ready front end for a multi-cycle dividerFsm: operand FIFO, single-issue launch, held result.
// Optional macro DIVIDER_SEQUENCER_DIVZERO_BYPASS_EN resolves divide-by-zero entries locally.
module divider_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cg,
  input  logic                         i_opValid,
  output logic                         o_opReady,
  input  logic [WIDTH-1:0]             i_dividend,
  input  logic [WIDTH-1:0]             i_divisor,
  output logic                         o_begin,
  output logic [WIDTH-1:0]             o_dividend,
  output logic [WIDTH-1:0]             o_divisor,
  input  logic                         i_divBusy,
  input  logic                         i_divDone,
  input  logic [WIDTH-1:0]             i_quotient,
  input  logic [WIDTH-1:0]             i_remainder,
  output logic                         o_resValid,
  input  logic                         i_resReady,
  output logic [WIDTH-1:0]             o_quotient,
  output logic [WIDTH-1:0]             o_remainder,
  output logic                         o_divByZero,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] fifo_dividend [DEPTH];
  logic [WIDTH-1:0] fifo_divisor  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head_dividend, head_divisor;
  logic             push, pop, bypass, begin_q;

  assign head_dividend = fifo_dividend[rd_ptr];
  assign head_divisor  = fifo_divisor[rd_ptr];

`ifdef DIVIDER_SEQUENCER_DIVZERO_BYPASS_EN
  assign bypass = (head_divisor == '0);
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else if (i_cg)
      state <= next_state;
  end

  // A bypassed divide-by-zero entry does not need the divider, so busy does not block it.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (bypass) begin
            pop        = 1'b1;
            next_state = HOLD;
          end else if (!i_divBusy) begin
            pop        = 1'b1;
            next_state = ISSUE;
          end
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (i_divDone) next_state = HOLD;
      HOLD:    if (i_resReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_opReady  = (count != FULL);
    o_resValid = (state == HOLD);
    o_begin    = begin_q;
    o_count    = count;
    push       = i_opValid && o_opReady;
  end

  always_ff @(posedge i_clk) begin
    if (i_cg && push) begin
      fifo_dividend[wr_ptr] <= i_dividend;
      fifo_divisor[wr_ptr]  <= i_divisor;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      begin_q     <= 1'b0;
      o_dividend  <= '0;
      o_divisor   <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_divByZero <= 1'b0;
    end else if (i_cg) begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      begin_q <= (next_state == ISSUE);
      // Operand registers only change on a real launch so the divider sees them stable.
      if (pop && !bypass) begin
        o_dividend <= head_dividend;
        o_divisor  <= head_divisor;
      end
      if (state == WAIT && i_divDone) begin
        o_quotient  <= i_quotient;
        o_remainder <= i_remainder;
        o_divByZero <= (o_divisor == '0);
      end else if (pop && bypass) begin
        o_quotient  <= '1;
        o_remainder <= head_dividend;
        o_divByZero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Bench for divider_sequencer: behavioural divider model, queue scoreboard, directed plus random steps.
module tb_divider_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             i_clk = 1'b0;
  logic             i_rst, i_cg, i_opValid, i_resReady;
  logic [WIDTH-1:0] i_dividend, i_divisor;
  logic             o_opReady, o_begin, o_resValid, o_divByZero;
  logic [WIDTH-1:0] o_dividend, o_divisor, o_quotient, o_remainder;
  logic [CW-1:0]    o_count;

  logic             div_busy = 1'b0;
  logic             div_done = 1'b0;
  logic [WIDTH-1:0] div_q = '0;
  logic [WIDTH-1:0] div_r = '0;
  int               div_cnt = 0;
  int               fixed_lat = 2;
  bit               keep_div = 1'b0;
  bit               rand_ready = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } res_t;

  res_t exp_q[$];

  int total = 0;
  int bad = 0;
  int begins = 0;
  int results = 0;
  bit hold_pending = 1'b0;
  logic [WIDTH-1:0] held_q, held_r;
  logic held_dbz;

  always #5 i_clk = ~i_clk;

  divider_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg),
    .i_opValid(i_opValid), .o_opReady(o_opReady),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_begin(o_begin), .o_dividend(o_dividend), .o_divisor(o_divisor),
    .i_divBusy(div_busy), .i_divDone(div_done),
    .i_quotient(div_q), .i_remainder(div_r),
    .o_resValid(o_resValid), .i_resReady(i_resReady),
    .o_quotient(o_quotient), .o_remainder(o_remainder),
    .o_divByZero(o_divByZero), .o_count(o_count)
  );

  // Stand-in for dividerFsm: busy for a configurable number of cycles, then a one-cycle done.
  always @(posedge i_clk) begin
    if (i_rst && !keep_div) begin
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_cnt  <= 0;
    end else if (i_cg) begin
      div_done <= 1'b0;
      if (div_busy) begin
        if (div_cnt == 0) begin
          div_busy <= 1'b0;
          div_done <= 1'b1;
          if (o_divisor == '0) begin
            div_q <= '1;
            div_r <= o_dividend;
          end else begin
            div_q <= o_dividend / o_divisor;
            div_r <= o_dividend % o_divisor;
          end
        end else begin
          div_cnt <= div_cnt - 1;
        end
      end else if (o_begin) begin
        div_busy <= 1'b1;
        div_cnt  <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t e;
    if (b == 0) begin
      e.q = {WIDTH{1'b1}};
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Evaluated at the falling edge with the inputs that the next rising edge will capture.
  task automatic monitor();
    res_t e;
    if (hold_pending) begin
      check("hold_valid", 32'(o_resValid), 32'(1));
      check("hold_q", 32'(o_quotient), 32'(held_q));
      check("hold_r", 32'(o_remainder), 32'(held_r));
      check("hold_dbz", 32'(o_divByZero), 32'(held_dbz));
    end
    hold_pending = !i_rst && o_resValid && !(i_resReady && i_cg);
    held_q = o_quotient;
    held_r = o_remainder;
    held_dbz = o_divByZero;
    if (i_rst) begin
      exp_q.delete();
    end else if (i_cg) begin
      if (o_begin) begin
        begins++;
        check("begin_while_busy", 32'(div_busy), 32'(0));
      end
      if (o_resValid && i_resReady) begin
        check("result_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_q", 32'(o_quotient), 32'(e.q));
          check("res_r", 32'(o_remainder), 32'(e.r));
          check("res_dbz", 32'(o_divByZero), 32'(e.dbz));
        end
        results++;
      end
      if (i_opValid && o_opReady)
        exp_q.push_back(model(i_dividend, i_divisor));
    end
  endtask

  task automatic tick();
    monitor();
    @(posedge i_clk);
    @(negedge i_clk);
    if (rand_ready)
      i_resReady = 1'($urandom_range(0, 1));
  endtask

  task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit accepted = 1'b0;
    int n = 0;
    i_opValid  = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    while (!accepted && n < 200) begin
      accepted = o_opReady;
      tick();
      n++;
    end
    i_opValid = 1'b0;
    check("push_accepted", 32'(accepted), 32'(1));
  endtask

  task automatic wait_res_valid(input int bound);
    int n = 0;
    while (!o_resValid && n < bound) begin
      tick();
      n++;
    end
    check("res_valid_wait", 32'(o_resValid), 32'(1));
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (n < bound && !(exp_q.size() == 0 && o_count == 0 && !o_resValid && !div_busy)) begin
      tick();
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'(0));
    check("drain_count", 32'(o_count), 32'(0));
    check("drain_valid", 32'(o_resValid), 32'(0));
  endtask

  initial begin
    int base_begins;
    int base_results;
    logic [WIDTH-1:0] ra, rb;

    i_rst = 1'b1; i_cg = 1'b1; i_opValid = 1'b0;
    i_dividend = '0; i_divisor = '0; i_resReady = 1'b0;
    @(negedge i_clk);
    tick();
    tick();
    check("reset_opReady", 32'(o_opReady), 32'(1));
    check("reset_begin", 32'(o_begin), 32'(0));
    check("reset_resValid", 32'(o_resValid), 32'(0));
    check("reset_count", 32'(o_count), 32'(0));
    check("reset_quotient", 32'(o_quotient), 32'(0));
    check("reset_remainder", 32'(o_remainder), 32'(0));
    check("reset_dbz", 32'(o_divByZero), 32'(0));
    check("reset_dividend", 32'(o_dividend), 32'(0));
    i_rst = 1'b0;

    $display("[TB] single op 100/7");
    base_begins = begins;
    push_op(8'd100, 8'd7);
    check("single_count_t1", 32'(o_count), 32'(1));
    check("single_begin_t1", 32'(o_begin), 32'(0));
    tick();
    check("single_begin_t2", 32'(o_begin), 32'(1));
    check("single_count_t2", 32'(o_count), 32'(0));
    tick();
    check("single_begin_t3", 32'(o_begin), 32'(0));
    wait_res_valid(40);
    check("single_q", 32'(o_quotient), 32'(14));
    check("single_r", 32'(o_remainder), 32'(2));
    check("single_dbz", 32'(o_divByZero), 32'(0));
    check("single_count_end", 32'(o_count), 32'(0));
    i_resReady = 1'b1;
    tick();
    check("single_valid_drop", 32'(o_resValid), 32'(0));
    check("single_begin_pulses", 32'(begins - base_begins), 32'(1));

    $display("[TB] back-to-back ops");
    base_results = results;
    push_op(8'd255, 8'd16);
    push_op(8'd9, 8'd3);
    push_op(8'd0, 8'd5);
    drain(200);
    check("b2b_results", 32'(results - base_results), 32'(3));

    $display("[TB] back-pressure with full fifo");
    i_resReady = 1'b0;
    base_results = results;
    push_op(8'd200, 8'd9);
    push_op(8'd50, 8'd5);
    push_op(8'd7, 8'd2);
    push_op(8'd99, 8'd10);
    push_op(8'd13, 8'd13);
    check("full_count", 32'(o_count), 32'(4));
    check("full_opReady", 32'(o_opReady), 32'(0));
    i_opValid = 1'b1; i_dividend = 8'd1; i_divisor = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold_count", 32'(o_count), 32'(4));
    end
    i_opValid = 1'b0;
    wait_res_valid(40);
    for (int i = 0; i < 3; i++) begin
      check("full_first_q", 32'(o_quotient), 32'(22));
      check("full_first_r", 32'(o_remainder), 32'(2));
      tick();
    end
    i_resReady = 1'b1;
    drain(300);
    check("full_results", 32'(results - base_results), 32'(5));

    $display("[TB] divide by zero 37/0");
    i_resReady = 1'b0;
    base_begins = begins;
    push_op(8'd37, 8'd0);
    check("dz_valid_t1", 32'(o_resValid), 32'(0));
    tick();
`ifdef DIVIDER_SEQUENCER_DIVZERO_BYPASS_EN
    check("dz_valid_t2", 32'(o_resValid), 32'(1));
    check("dz_begin_t2", 32'(o_begin), 32'(0));
`else
    check("dz_begin_t2", 32'(o_begin), 32'(1));
`endif
    wait_res_valid(40);
    check("dz_q", 32'(o_quotient), 32'(8'hFF));
    check("dz_r", 32'(o_remainder), 32'(37));
    check("dz_flag", 32'(o_divByZero), 32'(1));
`ifdef DIVIDER_SEQUENCER_DIVZERO_BYPASS_EN
    check("dz_begin_pulses", 32'(begins - base_begins), 32'(0));
`else
    check("dz_begin_pulses", 32'(begins - base_begins), 32'(1));
`endif
    i_resReady = 1'b1;
    drain(100);

    $display("[TB] reset during divide");
    i_resReady = 1'b0;
    fixed_lat = 10;
    keep_div = 1'b1;
    push_op(8'd60, 8'd7);
    push_op(8'd1, 8'd1);
    push_op(8'd2, 8'd1);
    push_op(8'd3, 8'd1);
    check("rst_pre_count", 32'(o_count), 32'(3));
    check("rst_pre_busy", 32'(div_busy), 32'(1));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_count", 32'(o_count), 32'(0));
    check("rst_valid", 32'(o_resValid), 32'(0));
    check("rst_opReady", 32'(o_opReady), 32'(1));
    for (int i = 0; i < 14; i++) begin
      tick();
      check("rst_late_done_ignored", 32'(o_resValid), 32'(0));
    end
    check("rst_div_finished", 32'(div_busy), 32'(0));
    keep_div = 1'b0;
    fixed_lat = 2;
    i_resReady = 1'b1;
    push_op(8'd81, 8'd9);
    tick();
    check("rst_relaunch_begin", 32'(o_begin), 32'(1));
    drain(100);

    $display("[TB] clock gate during issue");
    i_resReady = 1'b0;
    base_begins = begins;
    push_op(8'd100, 8'd7);
    tick();
    check("cg_begin_issue", 32'(o_begin), 32'(1));
    i_cg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cg_begin_held", 32'(o_begin), 32'(1));
      check("cg_busy_frozen", 32'(div_busy), 32'(0));
    end
    i_cg = 1'b1;
    tick();
    check("cg_begin_drop", 32'(o_begin), 32'(0));
    wait_res_valid(40);
    check("cg_q", 32'(o_quotient), 32'(14));
    check("cg_r", 32'(o_remainder), 32'(2));
    check("cg_begin_pulses", 32'(begins - base_begins), 32'(1));
    i_resReady = 1'b1;
    drain(100);

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    fixed_lat = -1;
    base_results = results;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      push_op(ra, rb);
      if ($urandom_range(0, 3) == 0)
        tick();
    end
    drain(3000);
    rand_ready = 1'b0;
    check("random_results", 32'(results - base_results), 32'(40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
